alu_muldiv_mips: RTL and testbench

Parametrised successor to the single-cycle MIPS ALU. It keeps the combinational ALU path and adds shift-right and unsigned-compare operations. It also adds an iterative multiply/divide unit that writes architectural HI/LO registers, which MFHI/MFLO read. The block sits in the execute stage of the datapath. The control unit must stall the PC while `busy` is high.

---
 rtl/alu_muldiv_mips_pkg.sv | 34 +++
 rtl/alu_muldiv_mips_muldiv_iter.sv | 145 ++++++++++++++
 rtl/alu_muldiv_mips.sv | 97 +++++++++
 tb/tb_alu_muldiv_mips.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_mips_pkg.sv
// Shared definitions for the execute-stage ALU and its iterative multiply/divide unit.
// The control encodings are also consumed by the instruction decoder.
package mips_pkg;

    // ALU operation select encodings
    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_NOR   = 4'd3;
    localparam logic [3:0] ALU_SLL   = 4'd4;
    localparam logic [3:0] ALU_SRL   = 4'd5;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_MULTU = 4'd10;
    localparam logic [3:0] ALU_DIVU  = 4'd11;
    localparam logic [3:0] ALU_MFHI  = 4'd12;
    localparam logic [3:0] ALU_MFLO  = 4'd13;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_FIN  = 2'd3
    } md_state_e;

    // True for the two codes that launch a multi-cycle operation
    function automatic logic is_muldiv_op(input logic [3:0] code);
        return (code == ALU_MULTU) || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_mips_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per clock.
// Owns the sequencer, iteration counter, working register and the HI/LO registers.
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product upper half, remaining multiplier bits}
    // Divide:   {partial remainder, dividend bits not yet consumed / quotient bits}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand for MULTU, divisor for DIVU
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               last_iter;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // One multiply step: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right; the carry lands in the top bit.
    assign mul_addend = acc_q[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring-divide step: bring the next dividend bit into the remainder and
    // subtract the divisor if it fits. A zero divisor always "fits", which yields an
    // all-ones quotient and leaves the dividend as the remainder.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ok    = (div_shift >= {1'b0, opnd_q});
    assign div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};

    // Sequencer next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            MD_IDLE: begin
                if (start && is_muldiv_op(control)) begin
                    cnt_d = '0;
                    if (control == ALU_MULTU) begin
                        state_d = MD_MUL;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        opnd_d  = a;
                    end else begin
                        state_d = MD_DIV;
                        acc_d   = {{WIDTH{1'b0}}, a};
                        opnd_d  = b;
                    end
                end
            end
            MD_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = MD_FIN;
                    cnt_d   = '0;
                    hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    lo_d    = mul_next[WIDTH-1:0];
                end
            end
            MD_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = MD_FIN;
                    cnt_d   = '0;
                    hi_d    = div_next[2*WIDTH-1:WIDTH];
                    lo_d    = div_next[WIDTH-1:0];
                end
            end
            MD_FIN: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        // Status flags are registered copies of the upcoming state
        busy_d = (state_d == MD_MUL) || (state_d == MD_DIV);
        done_d = (state_d == MD_FIN);
    end

    // State, counter, working registers and HI/LO; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_muldiv_mips.sv
// Execute-stage ALU: single-cycle combinational result mux plus the iterative
// MULTU/DIVU unit whose HI/LO registers are read back through MFHI/MFLO.
module alu_muldiv_mips
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    input  logic [SHW-1:0]   shift,
    input  logic             start,
    output logic [WIDTH-1:0] outalu,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] or_res;
    logic [WIDTH-1:0] nor_res;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] srl_res;
    logic [WIDTH-1:0] sra_res;
    logic             slt_res;
    logic             sltu_res;
    logic [WIDTH-1:0] hi_w;
    logic [WIDTH-1:0] lo_w;
    logic [WIDTH-1:0] result;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .control (control),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .hi      (hi_w),
        .lo      (lo_w)
    );

    // Bitwise logic unit, one slice per bit
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_res[gi] = a[gi] & b[gi];
            assign or_res[gi]  = a[gi] | b[gi];
            assign nor_res[gi] = ~(a[gi] | b[gi]);
        end
    endgenerate

    // Arithmetic, compare and shift results; shifts operate on rt (b)
    assign add_res  = a + b;
    assign sub_res  = a - b;
    assign slt_res  = ($signed(a) < $signed(b));
    assign sltu_res = (a < b);
    assign sll_res  = b << shift;
    assign srl_res  = b >> shift;
    assign sra_res  = $unsigned($signed(b) >>> shift);

    // Result select; launch codes and unused codes return zero
    always_comb begin
        result = '0;
        case (control)
            ALU_AND:  result = and_res;
            ALU_OR:   result = or_res;
            ALU_ADD:  result = add_res;
            ALU_NOR:  result = nor_res;
            ALU_SLL:  result = sll_res;
            ALU_SRL:  result = srl_res;
            ALU_SUB:  result = sub_res;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_res};
            ALU_SRA:  result = sra_res;
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu_res};
            ALU_MFHI: result = hi_w;
            ALU_MFLO: result = lo_w;
            default:  result = '0;
        endcase
    end

    assign outalu = result;
    assign zero   = (result == '0);
    assign hi     = hi_w;
    assign lo     = lo_w;

endmodule

// File: tb/tb_alu_muldiv_mips.sv
// Directed bench for alu_muldiv_mips: a 32-bit instance for the main scenarios and an
// 8-bit instance for the narrow-width multiply/divide. Expected results are queued by
// the stimulus and consumed by a negedge monitor.
module tb_alu_muldiv_mips;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [31:0] a, b, outalu, hi, lo;
    logic [3:0]  control;
    logic [4:0]  shift;
    logic        start, zero, busy, done;

    logic [7:0]  a8, b8, outalu8, hi8, lo8;
    logic [3:0]  control8;
    logic [2:0]  shift8;
    logic        start8, zero8, busy8, done8;

    alu_muldiv_mips #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .control(control), .shift(shift),
        .start(start), .outalu(outalu), .zero(zero), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    alu_muldiv_mips #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .control(control8), .shift(shift8),
        .start(start8), .outalu(outalu8), .zero(zero8), .busy(busy8), .done(done8),
        .hi(hi8), .lo(lo8)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } md_exp_t;

    typedef struct {
        logic [31:0] val;
        logic        z;
        string       name;
    } alu_exp_t;

    md_exp_t  md_q[$];
    md_exp_t  md8_q[$];
    alu_exp_t alu_q[$];
    logic     alu_chk = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare HI/LO on each done pulse and outalu/zero on each flagged cycle
    always @(negedge clk) begin
        md_exp_t  e;
        alu_exp_t x;
        if (done === 1'b1) begin
            if (md_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done32 got done=1 expected done=0");
            end else begin
                e = md_q.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
                $display("txn %s hi=%h lo=%h", e.name, hi, lo);
            end
        end
        if (done8 === 1'b1) begin
            if (md8_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8 got done=1 expected done=0");
            end else begin
                e = md8_q.pop_front();
                check({e.name, "_hi"}, {24'b0, hi8}, e.hi);
                check({e.name, "_lo"}, {24'b0, lo8}, e.lo);
                $display("txn %s hi=%h lo=%h", e.name, hi8, lo8);
            end
        end
        if (alu_chk) begin
            if (alu_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL alu_queue_empty got outalu=%h expected an entry", outalu);
            end else begin
                x = alu_q.pop_front();
                check(x.name, outalu, x.val);
                check({x.name, "_zero"}, {31'b0, zero}, {31'b0, x.z});
                $display("txn %s outalu=%h zero=%0d", x.name, outalu, zero);
            end
        end
    end

    // Apply one combinational operation for a cycle and queue its expected result
    task automatic alu_op(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] sh, input logic [31:0] ev, input logic ez,
                          input string nm);
        control = c;
        a       = av;
        b       = bv;
        shift   = sh;
        alu_q.push_back('{val: ev, z: ez, name: nm});
        alu_chk = 1'b1;
        @(posedge clk);
        #1;
        alu_chk = 1'b0;
    endtask

    // Pulse start for one cycle; returns 1 time unit after the launch edge E0
    task automatic launch(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv);
        control = c;
        a       = av;
        b       = bv;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    // Wait (bounded) for done; lat0 = edges already elapsed since E0
    task automatic wait_done(input int lat0, input int exp_lat, input string nm);
        int lat  = lat0;
        int bcnt = 0;
        if (busy === 1'b1) bcnt++;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat - lat0));
        check({nm, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    // 8-bit instance: launch, wait and check latency
    task automatic run8(input logic [3:0] c, input logic [7:0] av, input logic [7:0] bv,
                        input string nm);
        int lat = 0;
        control8 = c;
        a8       = av;
        b8       = bv;
        start8   = 1'b1;
        @(posedge clk);
        #1;
        start8   = 1'b0;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'd8);
        @(posedge clk);
        #1;
        check({nm, "_done_falls"}, {31'b0, done8}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        control  = ALU_AND;
        shift    = '0;
        start8   = 1'b0;
        a8       = '0;
        b8       = '0;
        control8 = ALU_AND;
        shift8   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Combinational operations
        alu_op(ALU_ADD,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, "add_wrap");
        alu_op(ALU_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, "slt_signed");
        alu_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, "sltu_unsigned");
        alu_op(ALU_AND,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, "and");
        alu_op(ALU_OR,   32'h1234_0000, 32'h0000_5678, 5'd0, 32'h1234_5678, 1'b0, "or");
        alu_op(ALU_NOR,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, "nor");
        alu_op(ALU_SUB,  32'h0, 32'h1, 5'd0, 32'hFFFF_FFFF, 1'b0, "sub_wrap");
        alu_op(ALU_SRA,  32'hFFFF_FFFF, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, "sra");
        alu_op(ALU_SRL,  32'hFFFF_FFFF, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, "srl");
        alu_op(ALU_SLL,  32'h0, 32'h1, 5'd31, 32'h8000_0000, 1'b0, "sll");
        alu_op(4'd14,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, "unused_code");
        alu_op(ALU_MULTU, 32'h5, 32'h6, 5'd0, 32'h0, 1'b1, "multu_outalu_zero");

        // MULTU 0xFFFFFFFF x 2
        md_q.push_back('{hi: 32'h1, lo: 32'hFFFF_FFFE, name: "multu_ffffffff_x2"});
        launch(ALU_MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_done(0, 32, "multu1");
        alu_op(ALU_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFE, 1'b0, "mflo_in_done_cycle");
        check("multu1_done_falls", {31'b0, done}, 32'd0);
        alu_op(ALU_MFHI, 32'h0, 32'h0, 5'd0, 32'h1, 1'b0, "mfhi_after_multu");

        // DIVU 100 / 7
        md_q.push_back('{hi: 32'd2, lo: 32'd14, name: "divu_100_7"});
        launch(ALU_DIVU, 32'd100, 32'd7);
        wait_done(0, 32, "divu1");
        @(posedge clk);
        #1;
        check("divu1_done_falls", {31'b0, done}, 32'd0);

        // DIVU 5 / 0
        md_q.push_back('{hi: 32'd5, lo: 32'hFFFF_FFFF, name: "divu_5_0"});
        launch(ALU_DIVU, 32'd5, 32'd0);
        wait_done(0, 32, "divu0");
        @(posedge clk);
        #1;

        // MULTU 3 x 5 with disturbances while running
        md_q.push_back('{hi: 32'd0, lo: 32'd15, name: "multu_3x5"});
        launch(ALU_MULTU, 32'd3, 32'd5);
        control = ALU_DIVU;
        a       = 32'd9;
        b       = 32'd9;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        check("midop_start_busy", {31'b0, busy}, 32'd1);
        alu_op(ALU_MFHI, 32'hAAAA_AAAA, 32'h5555_5555, 5'd0, 32'd5, 1'b0, "mfhi_during_busy");
        alu_op(ALU_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, "mflo_during_busy");
        wait_done(3, 32, "multu_3x5");
        control = ALU_DIVU;
        a       = 32'd50;
        b       = 32'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        check("start_in_fin_ignored", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("still_idle_after_fin", {31'b0, busy}, 32'd0);

        // Reset in the middle of a DIVU
        launch(ALU_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check("divu_running_before_reset", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("no_resume_after_abort", {31'b0, busy}, 32'd0);
        check("no_write_after_abort", lo, 32'd0);

        md_q.push_back('{hi: 32'd0, lo: 32'd63, name: "multu_after_reset"});
        launch(ALU_MULTU, 32'd7, 32'd9);
        wait_done(0, 32, "multu_after_reset");
        @(posedge clk);
        #1;

        // 8-bit instance
        md8_q.push_back('{hi: 32'hFE, lo: 32'h01, name: "w8_multu_ff_ff"});
        run8(ALU_MULTU, 8'hFF, 8'hFF, "w8_multu");
        md8_q.push_back('{hi: 32'd2, lo: 32'd22, name: "w8_divu_200_9"});
        run8(ALU_DIVU, 8'd200, 8'd9, "w8_divu");
        control8 = ALU_SRA;
        b8       = 8'h80;
        shift8   = 3'd3;
        #1;
        check("w8_sra", {24'b0, outalu8}, 32'h0000_00F0);

        @(posedge clk);
        #1;
        check("md_queue_drained", 32'(md_q.size()), 32'd0);
        check("md8_queue_drained", 32'(md8_q.size()), 32'd0);
        check("alu_queue_drained", 32'(alu_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
